cond_unit: RTL

Conditional-execution stage that sits directly downstream of the instruction decoder in the single-cycle ARM datapath. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags. It gates the decoder's raw PCS/RegW/MemW requests into the final PCSrc/RegWrite/MemWrite strobes, and updates flags under FlagW control. It also keeps executed/squashed instruction counters for debug.

---
 rtl/cond_if.sv | 31 +++
 rtl/cond_unit.sv | 79 +++++++
 2 files changed

// File: rtl/cond_if.sv
// Decoder-side bundle for the conditional-execution stage: raw requests and ALU flags in,
// gated strobes, stored flags and debug counters out.
interface cond_if #(
  parameter int unsigned CNT_W = 32
);
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             Stall;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SquashCount;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCount, SquashCount
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, ExecCount, SquashCount
  );
endinterface

// File: rtl/cond_unit.sv
// ARM conditional-execution stage: NZCV register, condition decode, write-strobe gating and
// saturating executed/squashed instruction counters.
module cond_unit #(
  parameter int unsigned CNT_W = 32
) (
  input  logic   clk,
  input  logic   reset,
  cond_if.slave  bus_io
);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic             n, z, c, v;
  logic             cond_ex;
  logic             advance;

  assign {n, z, c, v} = flags_q;
  assign advance      = ~bus_io.Stall;

  // Decode uses the stored flags only; the current ALU flags land next cycle.
  always_comb begin
    cond_ex = 1'b0;
    case (bus_io.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign bus_io.CondEx      = cond_ex;
  assign bus_io.PCSrc       = bus_io.PCS & cond_ex & advance;
  assign bus_io.RegWrite    = bus_io.RegW & cond_ex & ~bus_io.NoWrite & advance;
  assign bus_io.MemWrite    = bus_io.MemW & cond_ex & advance;
  assign bus_io.Flags       = flags_q;
  assign bus_io.ExecCount   = exec_q;
  assign bus_io.SquashCount = squash_q;

  always_comb begin
    flags_d  = flags_q;
    exec_d   = exec_q;
    squash_d = squash_q;
    if (advance) begin
      if (cond_ex) begin
        if (bus_io.FlagW[1]) flags_d[3:2] = bus_io.ALUFlags[3:2];
        if (bus_io.FlagW[0]) flags_d[1:0] = bus_io.ALUFlags[1:0];
        if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
      end else if (squash_q != '1) begin
        squash_d = squash_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      exec_q   <= '0;
      squash_q <= '0;
    end else begin
      flags_q  <= flags_d;
      exec_q   <= exec_d;
      squash_q <= squash_d;
    end
  end

endmodule
